// File: rtl/snake_collision.sv
// snake_collision: per-frame head/body/wall/food event resolution, food pixel renderer,
// and owner of snake length, score, food placement and game-over. Wall hits: SNAKE_WALL_COLLISION_EN.
module snake_collision #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned CELL      = 10,
   parameter int unsigned INIT_SIZE = 3,
   parameter int unsigned MAX_SIZE  = 31
) (
   input  logic       clk_d,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] xCount,
   input  logic [9:0] yCount,
   input  logic       snakeHead,
   input  logic       snakeBody,
   output logic       food,
   output logic [9:0] foodX,
   output logic [9:0] foodY,
   output logic [4:0] size,
   output logic [7:0] score,
   output logic       eat_pulse,
   output logic       game_over
);

   localparam int unsigned CW = 10;
   localparam int unsigned LW = 16;
   localparam int unsigned SW = 5;
   localparam int unsigned PW = 8;

   localparam logic [CW-1:0] CELL_W    = CW'(CELL);
   localparam logic [CW-1:0] V_EOF     = CW'(V_ACTIVE);
   localparam logic [CW-1:0] FOOD_INIT = CW'(100);
   localparam logic [SW-1:0] SIZE_INIT = SW'(INIT_SIZE);
   localparam logic [SW-1:0] SIZE_MAX  = SW'(MAX_SIZE);
   localparam logic [PW-1:0] SCORE_MAX = PW'(255);
   localparam logic [LW-1:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_x_d;
   logic [CW-1:0] r_y_d;
   logic [LW-1:0] r_lfsr;
   logic          r_food;
   logic [CW-1:0] r_food_x;
   logic [CW-1:0] r_food_y;
   logic [SW-1:0] r_size;
   logic [PW-1:0] r_score;
   logic          r_eat;
   logic          r_over;
   logic          r_hit_body;
   logic          r_hit_food;

   logic          w_eof;
   logic          w_clr_flags;
   logic          w_body_now;
   logic          w_food_now;
   logic          w_hit_body_any;
   logic          w_hit_food_any;
   logic          w_hit_wall_any;
   logic          w_food_pix;
   logic          w_lfsr_fb;
   logic [5:0]    w_col;
   logic [5:0]    w_row;
   logic [CW-1:0] w_new_fx;
   logic [CW-1:0] w_new_fy;

   assign food      = r_food;
   assign foodX     = r_food_x;
   assign foodY     = r_food_y;
   assign size      = r_size;
   assign score     = r_score;
   assign eat_pulse = r_eat;
   assign game_over = r_over;

   assign w_eof       = (r_x_d == '0) && (r_y_d == V_EOF);
   assign w_clr_flags = (r_state != S_PLAY) || w_eof || !start;

   assign w_body_now     = snakeHead & snakeBody;
   assign w_food_now     = snakeHead & r_food;
   assign w_hit_body_any = r_hit_body | w_body_now;
   assign w_hit_food_any = r_hit_food | w_food_now;

`ifdef SNAKE_WALL_COLLISION_EN
   localparam logic [CW-1:0] X_HI = CW'(H_ACTIVE - CELL);
   localparam logic [CW-1:0] Y_HI = CW'(V_ACTIVE - CELL);

   logic r_hit_wall;
   logic w_wall_now;

   assign w_wall_now = snakeHead && ((r_x_d < CELL_W) || (r_x_d >= X_HI) ||
                                     (r_y_d < CELL_W) || (r_y_d >= Y_HI));
   assign w_hit_wall_any = r_hit_wall | w_wall_now;

   // Sticky wall hit, cleared at frame end and outside PLAY
   always_ff @(posedge clk_d) begin
      if (reset || w_clr_flags) begin
         r_hit_wall <= 1'b0;
      end else begin
         r_hit_wall <= r_hit_wall | w_wall_now;
      end
   end
`else
   assign w_hit_wall_any = 1'b0;
`endif

   // Food cell from the LFSR, folded so the cell never touches the border ring
   assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   always_comb begin
      w_col = r_lfsr[5:0];
      w_row = r_lfsr[13:8];
      if (w_col == 6'd0) begin
         w_col = 6'd1;
      end else if (w_col == 6'd63) begin
         w_col = 6'd62;
      end
      if (w_row == 6'd0) begin
         w_row = 6'd1;
      end else if (w_row >= 6'd47) begin
         w_row = w_row - 6'd32;
      end
   end

   assign w_new_fx = CW'(w_col) * CELL_W;
   assign w_new_fy = CW'(w_row) * CELL_W;

   assign w_food_pix = (xCount > r_food_x) && (xCount < (r_food_x + CELL_W)) &&
                       (yCount > r_food_y) && (yCount < (r_food_y + CELL_W));

   // Coordinate delay, food pixel and free-running LFSR
   always_ff @(posedge clk_d) begin
      if (reset) begin
         r_x_d  <= '0;
         r_y_d  <= '0;
         r_food <= 1'b0;
         r_lfsr <= LFSR_SEED;
      end else begin
         r_x_d  <= xCount;
         r_y_d  <= yCount;
         r_food <= w_food_pix;
         r_lfsr <= {r_lfsr[LW-2:0], w_lfsr_fb};
      end
   end

   // Sticky body/food hits over the current frame
   always_ff @(posedge clk_d) begin
      if (reset || w_clr_flags) begin
         r_hit_body <= 1'b0;
         r_hit_food <= 1'b0;
      end else begin
         r_hit_body <= r_hit_body | w_body_now;
         r_hit_food <= r_hit_food | w_food_now;
      end
   end

   // Game FSM; a hit seen in the eof cycle itself still counts for this frame
   always_ff @(posedge clk_d) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_size   <= SIZE_INIT;
         r_score  <= '0;
         r_food_x <= FOOD_INIT;
         r_food_y <= FOOD_INIT;
         r_eat    <= 1'b0;
         r_over   <= 1'b0;
      end else begin
         r_eat <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_size   <= SIZE_INIT;
               r_score  <= '0;
               r_food_x <= FOOD_INIT;
               r_food_y <= FOOD_INIT;
               r_over   <= 1'b0;
               if (start) begin
                  r_state <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (!start) begin
                  r_state <= S_IDLE;
               end else if (w_eof) begin
                  if (w_hit_body_any || w_hit_wall_any) begin
                     r_state <= S_OVER;
                     r_over  <= 1'b1;
                  end else if (w_hit_food_any) begin
                     r_size   <= (r_size >= SIZE_MAX) ? SIZE_MAX : r_size + SW'(1);
                     r_score  <= (r_score == SCORE_MAX) ? SCORE_MAX : r_score + PW'(1);
                     r_eat    <= 1'b1;
                     r_food_x <= w_new_fx;
                     r_food_y <= w_new_fy;
                  end
               end
            end
            S_OVER: begin
               r_over <= 1'b1;
               if (!start) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snake_collision.sv
// Directed bench for snake_collision: food pixel table, eat, self-collision, wall,
// saturation and mid-frame reset, with an independent food-placement model.
module tb_snake_collision;

   logic       clk_d = 1'b0;
   logic       reset;
   logic       start;
   logic [9:0] xCount;
   logic [9:0] yCount;
   logic       snakeHead;
   logic       snakeBody;
   logic       food;
   logic [9:0] foodX;
   logic [9:0] foodY;
   logic [4:0] size;
   logic [7:0] score;
   logic       eat_pulse;
   logic       game_over;

   int n_total  = 0;
   int n_passed = 0;

   logic [15:0] m_lfsr;
   logic [15:0] m_eof_lfsr;
   logic [9:0]  m_xd;
   logic [9:0]  m_yd;
   logic [9:0]  ef_x;
   logic [9:0]  ef_y;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       exp_food;
   } vec_t;

   vec_t vecs[8];

   snake_collision dut (
      .clk_d     (clk_d),
      .reset     (reset),
      .start     (start),
      .xCount    (xCount),
      .yCount    (yCount),
      .snakeHead (snakeHead),
      .snakeBody (snakeBody),
      .food      (food),
      .foodX     (foodX),
      .foodY     (foodY),
      .size      (size),
      .score     (score),
      .eat_pulse (eat_pulse),
      .game_over (game_over)
   );

   always #5 clk_d = ~clk_d;

   // Reference LFSR and the value it held during the last end-of-frame cycle
   always @(posedge clk_d) begin
      if (reset) begin
         m_lfsr <= 16'hACE1;
      end else begin
         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
      m_xd <= xCount;
      m_yd <= yCount;
      if (m_xd == 10'd0 && m_yd == 10'd480) begin
         m_eof_lfsr <= m_lfsr;
      end
   end

   task automatic tick();
      @(posedge clk_d);
      #1;
   endtask

   task automatic drive(input int x, input int y, input logic h, input logic b);
      xCount    = 10'(x);
      yCount    = 10'(y);
      snakeHead = h;
      snakeBody = b;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         n_passed++;
      end
   endtask

   task automatic model_food();
      int c;
      int r;
      c = int'(m_eof_lfsr[5:0]);
      r = int'(m_eof_lfsr[13:8]);
      if (c == 0) c = 1;
      else if (c == 63) c = 62;
      if (r == 0) r = 1;
      else if (r >= 47) r = r - 32;
      ef_x = 10'(c * 10);
      ef_y = 10'(r * 10);
   endtask

   // Head over the food, then end of frame; returns just after the resolving edge
   task automatic eat_frame(input int x, input int y);
      drive(x, y, 1'b0, 1'b0);
      tick();
      drive(0, 480, 1'b1, 1'b0);
      tick();
      drive(320, 240, 1'b0, 1'b0);
      tick();
   endtask

   initial begin
      vecs[0] = '{x: 10'd105, y: 10'd105, exp_food: 1'b1};
      vecs[1] = '{x: 10'd100, y: 10'd105, exp_food: 1'b0};
      vecs[2] = '{x: 10'd101, y: 10'd105, exp_food: 1'b1};
      vecs[3] = '{x: 10'd109, y: 10'd109, exp_food: 1'b1};
      vecs[4] = '{x: 10'd110, y: 10'd105, exp_food: 1'b0};
      vecs[5] = '{x: 10'd105, y: 10'd100, exp_food: 1'b0};
      vecs[6] = '{x: 10'd105, y: 10'd110, exp_food: 1'b0};
      vecs[7] = '{x: 10'd101, y: 10'd101, exp_food: 1'b1};

      reset = 1'b1;
      start = 1'b0;
      drive(320, 240, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      check("rst_size", size, 3);
      check("rst_score", score, 0);
      check("rst_foodX", foodX, 100);
      check("rst_foodY", foodY, 100);
      check("rst_game_over", game_over, 0);
      check("rst_eat_pulse", eat_pulse, 0);
      check("rst_food", food, 0);
      ef_x = 10'd100;
      ef_y = 10'd100;

      // Food pixel strict-bound table against the idle cell at (100,100)
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].x, vecs[i].y, 1'b0, 1'b0);
         tick();
         check($sformatf("food_pix_%0d", i), food, vecs[i].exp_food);
      end

      // Eat once
      start = 1'b1;
      drive(320, 240, 1'b0, 1'b0);
      tick();
      eat_frame(105, 105);
      model_food();
      check("eat_pulse_hi", eat_pulse, 1);
      check("eat_size", size, 4);
      check("eat_score", score, 1);
      check("eat_foodX", foodX, ef_x);
      check("eat_foodY", foodY, ef_y);
      check("eat_foodX_min", int'(foodX >= 10'd10), 1);
      check("eat_foodY_min", int'(foodY >= 10'd10), 1);
      tick();
      check("eat_pulse_lo", eat_pulse, 0);
      drive(ef_x + 5, ef_y + 5, 1'b0, 1'b0);
      tick();
      check("new_food_in", food, 1);
      drive(ef_x + 10, ef_y + 5, 1'b0, 1'b0);
      tick();
      check("new_food_edge", food, 0);

      // Body hit and food hit in one frame: body wins
      drive(ef_x + 5, ef_y + 5, 1'b0, 1'b0);
      tick();
      drive(300, 300, 1'b1, 1'b0);
      tick();
      drive(0, 480, 1'b1, 1'b1);
      tick();
      drive(320, 240, 1'b0, 1'b0);
      tick();
      check("body_game_over", game_over, 1);
      check("body_size", size, 4);
      check("body_score", score, 1);
      check("body_no_eat", eat_pulse, 0);
      start = 1'b0;
      tick();
      check("over_exit_lag", game_over, 1);
      tick();
      check("idle_game_over", game_over, 0);
      check("idle_size", size, 3);
      ef_x = 10'd100;
      ef_y = 10'd100;

      // Head in the left border column
      start = 1'b1;
      tick();
      drive(5, 200, 1'b0, 1'b0);
      tick();
      drive(0, 480, 1'b1, 1'b0);
      tick();
      drive(320, 240, 1'b0, 1'b0);
      tick();
`ifdef SNAKE_WALL_COLLISION_EN
      check("wall_game_over", game_over, 1);
`else
      check("wall_game_over", game_over, 0);
`endif
      check("wall_size", size, 3);
      start = 1'b0;
      tick();
      tick();

      // Saturation: 255 eats, then one more
      start = 1'b1;
      tick();
      for (int i = 0; i < 255; i++) begin
         eat_frame(ef_x + 5, ef_y + 5);
         model_food();
      end
      check("sat_size_pre", size, 31);
      check("sat_score_pre", score, 255);
      eat_frame(ef_x + 5, ef_y + 5);
      model_food();
      check("sat_size", size, 31);
      check("sat_score", score, 255);
      check("sat_eat_pulse", eat_pulse, 1);
      check("sat_foodX", foodX, ef_x);
      check("sat_foodY", foodY, ef_y);

      // Reset in the middle of a frame with a pending food hit
      start = 1'b0;
      tick();
      tick();
      ef_x = 10'd100;
      ef_y = 10'd100;
      start = 1'b1;
      tick();
      eat_frame(105, 105);
      model_food();
      check("mid_pre_size", size, 4);
      drive(ef_x + 5, ef_y + 5, 1'b0, 1'b0);
      tick();
      drive(300, 200, 1'b1, 1'b0);
      tick();
      reset = 1'b1;
      drive(320, 240, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      check("mid_rst_size", size, 3);
      check("mid_rst_score", score, 0);
      check("mid_rst_foodX", foodX, 100);
      check("mid_rst_foodY", foodY, 100);
      check("mid_rst_game_over", game_over, 0);
      check("mid_rst_eat", eat_pulse, 0);
      drive(0, 480, 1'b0, 1'b0);
      tick();
      drive(320, 240, 1'b0, 1'b0);
      tick();
      check("mid_eof_no_eat", eat_pulse, 0);
      check("mid_eof_score", score, 0);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule

// File: doc/snake_collision.md
# snake_collision

Game-logic stage downstream of the snake body renderer. It consumes the per-pixel `snakeHead`/`snakeBody` flags and the raster coordinates, and renders the food cell. Once per frame it resolves head-vs-body, head-vs-wall and head-vs-food events. It owns snake length (`size`, fed back to the body renderer), score, food placement and the game-over state.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `CELL`, 10: grid cell size in pixels.
- `INIT_SIZE`, 3: snake length in IDLE.
- `MAX_SIZE`, 31: length saturation value (must fit 5 bits).

Ports:
- `clk_d` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: run level; high = game running.
- `xCount` in 10: raster column, advances each `clk_d`.
- `yCount` in 10: raster line.
- `snakeHead` in 1: head pixel flag for the coordinate presented one cycle earlier.
- `snakeBody` in 1: body pixel flag, same alignment as `snakeHead`.
- `food` out 1: food pixel flag, same alignment as `snakeHead`.
- `foodX` out 10: food cell left edge, pixels.
- `foodY` out 10: food cell top edge, pixels.
- `size` out 5: current snake length.
- `score` out 8: food eaten, saturating.
- `eat_pulse` out 1: one-cycle strobe when food is eaten.
- `game_over` out 1: high while in OVER.

## Operation
- State machine: IDLE, PLAY, OVER. Reset goes to IDLE from any state.
- IDLE:
  - Outputs forced: `size`=INIT_SIZE, `score`=0, `foodX`=100, `foodY`=100, `game_over`=0, sticky flags cleared.
  - `start`=1 moves to PLAY on the next edge.
- PLAY: three sticky flags accumulate over the frame.
  - hit_body: `snakeHead & snakeBody`.
  - hit_food: `snakeHead & food`.
  - hit_wall: `snakeHead` with aligned coordinate x_d < CELL, x_d ≥ H_ACTIVE−CELL, y_d < CELL, or y_d ≥ V_ACTIVE−CELL.
- Frame end: eof strobe when the aligned coordinate (x_d, y_d) = (0, V_ACTIVE). At eof, resolve in this priority order, then clear all sticky flags:
  1. hit_body or hit_wall → OVER.
  2. Otherwise hit_food → `size`+1 (saturate at MAX_SIZE), `score`+1 (saturate at 255), `eat_pulse`=1, and relocate food.
  3. Otherwise no change.
- OVER:
  - `game_over`=1; `size`, `score` and food position frozen.
  - `start`=0 returns to IDLE.
- `start`=0 in PLAY returns to IDLE directly.
- Food relocation: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, advances every cycle in every state.
  - Column c = lfsr[5:0], mapped 0→1 and 63→62.
  - Row r = lfsr[13:8], mapped 0→1 and 47..63→r−32.
  - `foodX` = c·CELL, `foodY` = r·CELL, computed with 10-bit arithmetic.
  - Food is not checked against the snake.
- Food pixel: `food` registered as (`xCount` > foodX && `xCount` < foodX+CELL) && (`yCount` > foodY && `yCount` < foodY+CELL). Strict bounds match the body renderer.

## Timing
- x_d/y_d are `xCount`/`yCount` registered once, so they align with `snakeHead`, `snakeBody` and `food`.
- Event resolution: `size`, `score`, `foodX`/`foodY`, `game_over` and `eat_pulse` update on the edge after the eof strobe cycle. `eat_pulse` is high for exactly one cycle.
- A hit sampled in the eof cycle itself counts toward the current frame.
- A new food position takes effect in the `food` flag on the next cycle.
- `start` falling while `game_over`=1: IDLE on the next edge, with `game_over` low one cycle later.
- Reset mid-frame: all state returns to IDLE values on the next edge; the partial frame is discarded.
- Reset values:
  - `food`=0, `foodX`=100, `foodY`=100.
  - `size`=INIT_SIZE, `score`=0.
  - `eat_pulse`=0, `game_over`=0.

## Configuration
- `SNAKE_WALL_COLLISION_EN` defined: hit_wall is evaluated and ends the game as described above.
- Not defined: hit_wall logic is compiled out; only body collision ends the game, and wall handling is left to the movement logic.

## Test plan
- Reset: assert `reset` for 2 cycles → `size`=3, `score`=0, `foodX`=`foodY`=100, `game_over`=0, `eat_pulse`=0.
- Eat: `start`=1, head pixel at (105,105) within a frame → after eof, `size`=4, `score`=1, one-cycle `eat_pulse`, food moved to the LFSR-derived cell (check against a model), both coordinates ≥10.
- Self-collision with food: `snakeHead` and `snakeBody` both high at (300,300), plus a food hit in the same frame → after eof, `game_over`=1, `size`/`score` unchanged, no `eat_pulse`. Then `start`=0 → IDLE, `size`=3.
- Wall: head at (5,200), macro defined → `game_over`=1 after eof. Same stimulus with macro undefined → stays in PLAY.
- Saturation: preload `size`=31, `score`=255, eat once → both unchanged, `eat_pulse` still fires.
- Reset mid-frame: food hit registered, then `reset` at line 200 → no `eat_pulse`, IDLE values restored.
